// File: rtl/scan_shift_ctrl.sv
// Scan chain sequencer: shifts a stimulus word in, pulses one capture cycle,
// then unloads the chain into response. All outputs decode from state/counter.
module scan_shift_ctrl #(
    parameter int CHAIN_LEN = 16,
    parameter bit SO_INV    = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 cg_en,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] response
);

    localparam int CW = $clog2(CHAIN_LEN) + 1;
    localparam int IW = $clog2(CHAIN_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_IN,
        S_CAPTURE,
        S_SHIFT_OUT,
        S_DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [CHAIN_LEN-1:0]   pat_reg;
    logic [IW-1:0]          idx;
    logic                   cnt_last;

    assign idx      = cnt[IW-1:0];
    assign cnt_last = (cnt == CW'(CHAIN_LEN - 1));

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state    <= S_IDLE;
            cnt      <= '0;
            pat_reg  <= '0;
            response <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && start)
                pat_reg <= pattern;
            if (state == S_SHIFT_OUT)
                response[idx] <= SO ^ SO_INV;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SHIFT_IN;
                    cnt_nxt   = '0;
                end
            end
            S_SHIFT_IN: begin
                if (cnt_last) begin
                    state_nxt = S_CAPTURE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_CAPTURE: begin
                state_nxt = S_SHIFT_OUT;
                cnt_nxt   = '0;
            end
            S_SHIFT_OUT: begin
                if (cnt_last) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Chain clock runs through shift and capture; gated off in IDLE and DONE.
    always_comb begin
        SE    = 1'b0;
        SI    = 1'b0;
        cg_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            S_SHIFT_IN: begin
                SE    = 1'b1;
                SI    = pat_reg[idx];
                cg_en = 1'b1;
                busy  = 1'b1;
            end
            S_CAPTURE: begin
                cg_en = 1'b1;
                busy  = 1'b1;
            end
            S_SHIFT_OUT: begin
                SE    = 1'b1;
                cg_en = 1'b1;
                busy  = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_scan_shift_ctrl.sv
// Drives two 4-cell controllers (plain and inverted SO) against behavioural
// chains; expected outputs come from cycle offsets since start acceptance.
module tb_scan_shift_ctrl;

    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         RESETN;
    logic         start;
    logic [N-1:0] pattern;
    logic         frc;

    logic         se0, si0, cg0, busy0, done0;
    logic         se1, si1, cg1, busy1, done1;
    logic [N-1:0] resp0, resp1;
    logic [N-1:0] ch0, ch1;
    logic         so0, so1;

    int           checks = 0;
    int           passes = 0;
    int           ndone  = 0;

    // Reference model: t = cycles since acceptance (0 = idle).
    int           t = 0;
    logic [N-1:0] pat_lat = '0;
    logic [N-1:0] exp_r0  = '0;
    logic [N-1:0] exp_r1  = '0;
    logic         cap_frc = 1'b0;

    always #5 CLK = ~CLK;

    scan_shift_ctrl #(.CHAIN_LEN(N), .SO_INV(1'b0)) u0 (
        .CLK(CLK), .RESETN(RESETN), .start(start), .pattern(pattern), .SO(so0),
        .SE(se0), .SI(si0), .cg_en(cg0), .busy(busy0), .done(done0), .response(resp0)
    );

    scan_shift_ctrl #(.CHAIN_LEN(N), .SO_INV(1'b1)) u1 (
        .CLK(CLK), .RESETN(RESETN), .start(start), .pattern(pattern), .SO(so1),
        .SE(se1), .SI(si1), .cg_en(cg1), .busy(busy1), .done(done1), .response(resp1)
    );

    // Behavioural chains: cell 0 takes SI, last cell drives SO; capture either
    // holds state or forces every cell to 1 depending on frc.
    assign so0 = ch0[N-1];
    assign so1 = ch1[N-1];

    always @(posedge CLK) begin
        if (cg0) begin
            if (se0)      ch0 <= {ch0[N-2:0], si0};
            else if (frc) ch0 <= '1;
        end
        if (cg1) begin
            if (se1)      ch1 <= {ch1[N-2:0], si1};
            else if (frc) ch1 <= '1;
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    endtask

    task automatic chk4(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    endtask

    // One cycle: check this cycle's outputs, drive next inputs, advance model.
    task automatic run(input logic st, input logic [N-1:0] pat, input logic rn, input logic f);
        logic e_se, e_si, e_cg, e_busy, e_done;
        @(negedge CLK);
        e_se   = (t >= 1 && t <= N) || (t >= N + 2 && t <= 2 * N + 1);
        e_cg   = (t >= 1 && t <= 2 * N + 1);
        e_busy = (t != 0);
        e_done = (t == 2 * N + 2);
        e_si   = (t >= 1 && t <= N) ? pat_lat[t-1] : 1'b0;
        chk1("se0", se0, e_se);     chk1("se1", se1, e_se);
        chk1("si0", si0, e_si);     chk1("si1", si1, e_si);
        chk1("cg0", cg0, e_cg);     chk1("cg1", cg1, e_cg);
        chk1("busy0", busy0, e_busy); chk1("busy1", busy1, e_busy);
        chk1("done0", done0, e_done); chk1("done1", done1, e_done);
        if (t <= N + 2 || t == 2 * N + 2) begin
            chk4("resp0", resp0, exp_r0);
            chk4("resp1", resp1, exp_r1);
        end
        if (done0) ndone++;

        start   = st;
        pattern = pat;
        RESETN  = rn;
        frc     = f;

        if (!rn) begin
            t      = 0;
            exp_r0 = '0;
            exp_r1 = '0;
        end else if (t == 0) begin
            if (st) begin
                t       = 1;
                pat_lat = pat;
            end
        end else if (t == N + 1) begin
            cap_frc = f;
            t++;
        end else if (t == 2 * N + 1) begin
            exp_r0 = cap_frc ? '1 : pat_lat;
            exp_r1 = ~exp_r0;
            t++;
        end else if (t == 2 * N + 2) begin
            t = 0;
        end else begin
            t++;
        end
    endtask

    initial begin
        RESETN  = 1'b0;
        start   = 1'b1;
        pattern = 4'hF;
        frc     = 1'b0;
        ch0     = '0;
        ch1     = '0;
        repeat (2) @(posedge CLK);

        // start asserted together with reset is dropped
        run(1'b1, 4'hF, 1'b0, 1'b0);
        run(1'b0, 4'h0, 1'b1, 1'b0);
        run(1'b0, 4'h0, 1'b1, 1'b0);

        // holding chain, 1011, extra starts at cycles 3 and 7 ignored
        ndone = 0;
        run(1'b1, 4'b1011, 1'b1, 1'b0);
        for (int c = 1; c <= 12; c++)
            run((c == 3 || c == 7), 4'($urandom), 1'b1, 1'b0);
        chk1("single_done", (ndone == 1), 1'b1);

        // capture forces ones
        run(1'b1, 4'($urandom), 1'b1, 1'b1);
        for (int c = 1; c <= 12; c++)
            run(1'b0, 4'($urandom), 1'b1, 1'b1);
        chk4("force_resp0", resp0, 4'b1111);

        // holding chain, 0110 through inverted-SO controller
        run(1'b1, 4'b0110, 1'b1, 1'b0);
        for (int c = 1; c <= 12; c++)
            run(1'b0, 4'($urandom), 1'b1, 1'b0);
        chk4("inv_resp1", resp1, 4'b1001);

        // reset during SHIFT_OUT at cycle 6, then a fresh sequence at cycle 7
        run(1'b1, 4'b1100, 1'b1, 1'b0);
        for (int c = 1; c <= 5; c++)
            run(1'b0, 4'($urandom), 1'b1, 1'b0);
        run(1'b0, 4'($urandom), 1'b0, 1'b0);
        run(1'b1, 4'b0101, 1'b1, 1'b0);
        for (int c = 1; c <= 12; c++)
            run(1'b0, 4'($urandom), 1'b1, 1'b0);

        // start held high for 30 cycles
        ndone = 0;
        for (int c = 0; c < 30; c++)
            run(1'b1, 4'($urandom), 1'b1, 1'($urandom));
        for (int c = 0; c < 12; c++)
            run(1'b0, 4'($urandom), 1'b1, 1'b0);
        chk1("held_start_done3", (ndone == 3), 1'b1);

        // random traffic with occasional reset
        for (int c = 0; c < 400; c++)
            run(($urandom_range(0, 3) == 0), 4'($urandom),
                ($urandom_range(0, 49) != 0), 1'($urandom));
        for (int c = 0; c < 12; c++)
            run(1'b0, 4'($urandom), 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
